div32_seq: RTL and testbench
============================

// Module: div32_seq
// PURPOSE
//   Iterative 32-bit restoring divider for the RV32M DIV/DIVU/REM/REMU path; the
//   subtract-side counterpart of adder32. Computes one quotient bit per cycle by
//   shift-and-subtract and returns quotient and remainder with RISC-V semantics.
//   Sits beside the ALU in EX and stalls the pipeline via o_busy_1.
// PARAMETERS
//   XLEN  32  operand/result width; iteration count equals XLEN
// PORTS
//   i_clk           in   1     clock, rising edge
//   i_rst_n         in   1     asynchronous active-low reset
//   i_start_1       in   1     start request, sampled only in IDLE
//   i_signed_1      in   1     1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU)
//   i_dividend_32   in   XLEN  dividend, sampled with i_start_1
//   i_divisor_32    in   XLEN  divisor, sampled with i_start_1
//   o_busy_1        out  1     high whenever state != IDLE
//   o_done_1        out  1     one-cycle pulse: results valid
//   o_quotient_32   out  XLEN  quotient, held until the next accepted start
//   o_remainder_32  out  XLEN  remainder, held until the next accepted start
// BEHAVIOUR
//   Reset (async, i_rst_n=0): state IDLE; o_busy_1=0, o_done_1=0,
//     o_quotient_32=0, o_remainder_32=0; counter and work registers cleared.
//   FSM: IDLE -> CALC (normal start) | DONE (special-case start);
//     CALC -> DONE after XLEN iterations; DONE -> IDLE unconditionally.
//   Start accepted at rising edge N with state IDLE and i_start_1=1.
//     Operands latched at N; later input changes are ignored.
//   Start while busy (CALC or DONE) ignored; no queuing.
//   Normal latency: CALC occupies cycles N+1..N+XLEN; o_done_1=1 in cycle
//     N+XLEN+1 (DONE); o_busy_1=0 from N+XLEN+2.
//   Iteration: rem = {rem[XLEN-2:0], dvd[XLEN-1]}; dvd <<= 1;
//     diff = {1'b0,rem} - {1'b0,|dvs|} on XLEN+1 bits; if diff[XLEN]==0 then
//     rem = diff[XLEN-1:0], quotient bit = 1, else rem kept, bit = 0.
//   Signed mode: magnitudes used internally; quotient negated iff operand signs
//     differ; remainder takes the dividend's sign. Correction applied on the
//     CALC->DONE edge so outputs are final when o_done_1 is high.
//   Divide by zero (divisor==0, either mode): no CALC; o_done_1 at N+1;
//     quotient = all ones (0xFFFFFFFF), remainder = dividend.
//   Signed overflow (dividend==0x80000000, divisor==0xFFFFFFFF, signed):
//     no CALC; o_done_1 at N+1; quotient = 0x80000000, remainder = 0.
//   o_done_1 is high exactly one cycle per accepted start; never in IDLE/CALC.
//   Reset mid-CALC: operation abandoned, outputs per reset values, no done pulse.
//   Outputs change only at accepted start (cleared to 0 during CALC not
//     required; they may hold the previous result) and at CALC/special ->DONE.
// TESTING
//   DIVU 100/7, start at edge N -> o_done_1 at N+33, quotient=14, remainder=2;
//     o_busy_1 high N+1..N+33.
//   DIV -7/2 (0xFFFFFFF9, 2, signed) -> quotient=0xFFFFFFFD (-3),
//     remainder=0xFFFFFFFF (-1); DIV 7/-2 -> quotient=-3, remainder=1.
//   DIVU 0x12345678/0 -> done at N+1, quotient=0xFFFFFFFF, remainder=0x12345678;
//     DIV 0x80000000/0xFFFFFFFF -> done at N+1, q=0x80000000, r=0.
//   DIVU 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0; DIVU 5/0xFFFFFFFF -> q=0, r=5.
//   Start pulsed again at N+10 with new operands -> ignored; result of first
//     op unchanged, single done pulse at N+33.
//   Assert i_rst_n=0 at N+15 mid-CALC -> immediate IDLE, all outputs 0, no
//     done; new start after release completes normally with correct result.

Source files
------------

// File: rtl/div32_seq.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// Produces one quotient bit per cycle and returns the RISC-V quotient and remainder.
// Divide-by-zero and signed overflow skip the iteration and finish in one cycle.
module div32_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start_1,
  input  logic            i_signed_1,
  input  logic [XLEN-1:0] i_dividend_32,
  input  logic [XLEN-1:0] i_divisor_32,
  output logic            o_busy_1,
  output logic            o_done_1,
  output logic [XLEN-1:0] o_quotient_32,
  output logic [XLEN-1:0] o_remainder_32
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT           state;
  logic [CW-1:0]   iterCnt;
  logic [XLEN-1:0] dvdReg;   // dividend magnitude, refilled from the LSB with quotient bits
  logic [XLEN-1:0] dvsReg;   // divisor magnitude
  logic [XLEN-1:0] remReg;   // partial remainder
  logic            negQuo;
  logic            negRem;

  logic            dvdNeg;
  logic            dvsNeg;
  logic [XLEN-1:0] dvdAbs;
  logic [XLEN-1:0] dvsAbs;
  logic            divZero;
  logic            sgnOvf;
  logic [XLEN-1:0] remShift;
  logic [XLEN:0]   diff;
  logic            quoBit;
  logic [XLEN-1:0] remNext;
  logic [XLEN-1:0] quoNext;
  logic [XLEN-1:0] quoFinal;
  logic [XLEN-1:0] remFinal;

  // Operand decode at start and one shift-and-subtract step with sign correction
  always_comb begin
    dvdNeg   = i_signed_1 & i_dividend_32[XLEN-1];
    dvsNeg   = i_signed_1 & i_divisor_32[XLEN-1];
    dvdAbs   = dvdNeg ? (XLEN'(0) - i_dividend_32) : i_dividend_32;
    dvsAbs   = dvsNeg ? (XLEN'(0) - i_divisor_32) : i_divisor_32;
    divZero  = (i_divisor_32 == '0);
    sgnOvf   = i_signed_1 & (i_dividend_32 == MIN_NEG) & (i_divisor_32 == '1);
    remShift = {remReg[XLEN-2:0], dvdReg[XLEN-1]};
    diff     = {1'b0, remShift} - {1'b0, dvsReg};
    quoBit   = ~diff[XLEN];
    remNext  = quoBit ? diff[XLEN-1:0] : remShift;
    quoNext  = {dvdReg[XLEN-2:0], quoBit};
    quoFinal = negQuo ? (XLEN'(0) - quoNext) : quoNext;
    remFinal = negRem ? (XLEN'(0) - remNext) : remNext;
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      iterCnt        <= '0;
      dvdReg         <= '0;
      dvsReg         <= '0;
      remReg         <= '0;
      negQuo         <= 1'b0;
      negRem         <= 1'b0;
      o_busy_1       <= 1'b0;
      o_done_1       <= 1'b0;
      o_quotient_32  <= '0;
      o_remainder_32 <= '0;
    end else begin
      case (state)
        IDLE: begin
          o_done_1 <= 1'b0;
          if (i_start_1) begin
            o_busy_1 <= 1'b1;
            if (divZero) begin
              o_quotient_32  <= '1;
              o_remainder_32 <= i_dividend_32;
              o_done_1       <= 1'b1;
              state          <= DONE;
            end else if (sgnOvf) begin
              o_quotient_32  <= MIN_NEG;
              o_remainder_32 <= '0;
              o_done_1       <= 1'b1;
              state          <= DONE;
            end else begin
              dvdReg  <= dvdAbs;
              dvsReg  <= dvsAbs;
              remReg  <= '0;
              iterCnt <= '0;
              negQuo  <= dvdNeg ^ dvsNeg;
              negRem  <= dvdNeg;
              state   <= CALC;
            end
          end
        end
        CALC: begin
          dvdReg  <= quoNext;
          remReg  <= remNext;
          iterCnt <= iterCnt + CW'(1);
          if (iterCnt == LAST_ITER) begin
            o_quotient_32  <= quoFinal;
            o_remainder_32 <= remFinal;
            o_done_1       <= 1'b1;
            state          <= DONE;
          end
        end
        DONE: begin
          o_done_1 <= 1'b0;
          o_busy_1 <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          o_done_1 <= 1'b0;
          o_busy_1 <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div32_seq.sv
// Self-checking bench for div32_seq: directed RV32M cases, busy-start and reset-mid-op.
module tb_div32_seq;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        start = 1'b0;
  logic        sgn = 1'b0;
  logic [31:0] dvd = '0;
  logic [31:0] dvs = '0;
  logic        busy;
  logic        done;
  logic [31:0] quo;
  logic [31:0] rem;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } expT;

  expT sb[$];

  div32_seq #(.XLEN(32)) dut (
    .i_clk          (clk),
    .i_rst_n        (rstN),
    .i_start_1      (start),
    .i_signed_1     (sgn),
    .i_dividend_32  (dvd),
    .i_divisor_32   (dvs),
    .o_busy_1       (busy),
    .o_done_1       (done),
    .o_quotient_32  (quo),
    .o_remainder_32 (rem)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model from RISC-V M-extension semantics
  function automatic expT model(input logic [31:0] a, input logic [31:0] b, input logic s);
    expT e;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.lat = 0;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000; e.r = 32'd0; e.lat = 0;
    end else if (s) begin
      e.q = 32'($signed(a) / $signed(b));
      e.r = 32'($signed(a) % $signed(b));
      e.lat = 32;
    end else begin
      e.q = a / b; e.r = a % b; e.lat = 32;
    end
    return e;
  endfunction

  // Drive a start before edge N, push the expectation, then scramble inputs
  task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input expT e);
    @(negedge clk);
    dvd = a; dvs = b; sgn = s; start = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    dvd = $urandom; dvs = $urandom; sgn = 1'($urandom_range(0, 1));
    check({tag, "_busy0"}, {31'b0, busy}, 32'd1);
  endtask

  // Wait for done (bounded), compare against scoreboard; optional ignored start at N+pulseAt
  task automatic waitDone(input string tag, input int pulseAt);
    int  cyc;
    expT e;
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (cyc == pulseAt - 1) begin
        start = 1'b1; dvd = 32'd999; dvs = 32'd1; sgn = 1'b0;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
      if (done !== 1'b1) check({tag, "_busy"}, {31'b0, busy}, 32'd1);
    end
    e = sb.pop_front();
    check({tag, "_lat"}, 32'(cyc), 32'(e.lat));
    check({tag, "_quo"}, quo, e.q);
    check({tag, "_rem"}, rem, e.r);
    @(posedge clk);
    #1;
    check({tag, "_doneOff"}, {31'b0, done}, 32'd0);
    check({tag, "_idle"}, {31'b0, busy}, 32'd0);
    check({tag, "_quoHeld"}, quo, e.q);
    check({tag, "_remHeld"}, rem, e.r);
  endtask

  task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [31:0] q, input logic [31:0] r, input int lat);
    expT e;
    e.q = q; e.r = r; e.lat = lat;
    issue(tag, a, b, s, e);
    waitDone(tag, 0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_quo", quo, 32'd0);
    check("rst_rem", rem, 32'd0);
    @(negedge clk);
    rstN = 1'b1;

    // Directed cases
    runOp("divu_100_7",  32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          32);
    runOp("div_m7_2",    32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  32);
    runOp("div_7_m2",    32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          32);
    runOp("divu_by0",    32'h1234_5678,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h1234_5678,  0);
    runOp("div_by0",     32'hFFFF_FFF0,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFF0,  0);
    runOp("div_ovf",     32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          0);
    runOp("divu_max_1",  32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          32);
    runOp("divu_5_max",  32'd5,          32'hFFFF_FFFF,  1'b0, 32'd0,          32'd5,          32);
    runOp("divu_min_m1", 32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  32);
    runOp("div_min_2",   32'h8000_0000,  32'd2,          1'b1, 32'hC000_0000,  32'd0,          32);

    // Start pulsed at N+10 while busy must be ignored
    issue("busy_start", 32'd1000, 32'd3, 1'b0, model(32'd1000, 32'd3, 1'b0));
    waitDone("busy_start", 10);

    // Random operands against the model
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = (i == 3) ? 32'($urandom_range(1, 15)) : $urandom >> $urandom_range(0, 31);
      rs = 1'(i & 1);
      issue("rand", ra, rb, rs, model(ra, rb, rs));
      waitDone("rand", 0);
    end

    // Reset asserted mid-CALC abandons the operation
    @(negedge clk);
    dvd = 32'd100; dvs = 32'd7; sgn = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) begin
      @(posedge clk);
      #1;
    end
    rstN = 1'b0;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_quo", quo, 32'd0);
    check("midrst_rem", rem, 32'd0);
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      check("midrst_noDone", {31'b0, done}, 32'd0);
    end
    @(negedge clk);
    rstN = 1'b1;
    runOp("after_rst", 32'd12345, 32'd100, 1'b0, 32'd123, 32'd45, 32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
